// File: rtl/alu_seq_pkg.sv
// Shared encodings for the microstep sequencer: FSM states, ALU opcode classes
// and IR field layout (opcode, then ra/rb/rc packed MSB first).
package alu_seq_pkg;

  typedef enum logic [3:0] {
    ST_IDLE = 4'd0,
    ST_T0   = 4'd1,
    ST_T1   = 4'd2,
    ST_T2   = 4'd3,
    ST_T3   = 4'd4,
    ST_T4   = 4'd5,
    ST_T5   = 4'd6,
    ST_T6   = 4'd7
  } state_t;

  localparam logic [4:0] OP_ALU_FIRST = 5'h03;
  localparam logic [4:0] OP_ALU_LAST  = 5'h0E;
  localparam logic [4:0] OP_MUL       = 5'h0F;
  localparam logic [4:0] OP_DIV       = 5'h10;

  // Field index counted from the MSB end of the IR: opcode first, then ra, rb, rc.
  localparam int FLD_OP = 0;
  localparam int FLD_RA = 1;
  localparam int FLD_RB = 2;
  localparam int FLD_RC = 3;

  function automatic int field_lsb(input int data_w, input int op_w, input int reg_w,
                                   input int idx);
    return data_w - op_w - idx * reg_w;
  endfunction

endpackage

// File: rtl/alu_seq_ctrl_if.sv
// Sequencer <-> datapath control bundle; master is the sequencer side, slave the datapath side.
interface alu_seq_ctrl_if #(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
);
  logic                start;
  logic [DATA_W-1:0]   ir_in;
  logic                mem_ready;
  logic [NUM_REGS-1:0] R_rd;
  logic [NUM_REGS-1:0] R_wrt;
  logic                PC_out, MDR_out, Zlo_out, Zhi_out;
  logic                PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd;
  logic                IncPC, Read;
  logic [OP_W-1:0]     op_sel;
  logic                busy, done, illegal, bus_err;
  logic [3:0]          state_view;

  modport master (
    input  start, ir_in, mem_ready,
    output R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out,
           PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
           IncPC, Read, op_sel, busy, done, illegal, bus_err, state_view
  );

  modport slave (
    output start, ir_in, mem_ready,
    input  R_rd, R_wrt, PC_out, MDR_out, Zlo_out, Zhi_out,
           PC_rd, MAR_rd, MDR_rd, IR_rd, Y_rd, Zlo_rd, Zhi_rd, HI_rd, LO_rd,
           IncPC, Read, op_sel, busy, done, illegal, bus_err, state_view
  );

endinterface

// File: rtl/alu_seq_decode.sv
// Combinational IR decode: field extraction, opcode legality/MUL-DIV class, one-hot register selects.
// MUL/DIV opcodes are legal only when ALU_MULDIV_EN is defined.
module alu_seq_decode
  import alu_seq_pkg::*;
#(
  parameter int DATA_W   = 32,
  parameter int NUM_REGS = 16,
  parameter int OP_W     = 5
) (
  input  logic [DATA_W-1:0]   ir,
  output logic [OP_W-1:0]     opcode,
  output logic [NUM_REGS-1:0] ra_oh,
  output logic [NUM_REGS-1:0] rb_oh,
  output logic [NUM_REGS-1:0] rc_oh,
  output logic                legal,
  output logic                is_muldiv
);
  localparam int REG_W = $clog2(NUM_REGS);

  logic [REG_W-1:0] ra, rb, rc;
  logic             is_alu;

  assign opcode = OP_W'(ir >> field_lsb(DATA_W, OP_W, REG_W, FLD_OP));
  assign ra     = REG_W'(ir >> field_lsb(DATA_W, OP_W, REG_W, FLD_RA));
  assign rb     = REG_W'(ir >> field_lsb(DATA_W, OP_W, REG_W, FLD_RB));
  assign rc     = REG_W'(ir >> field_lsb(DATA_W, OP_W, REG_W, FLD_RC));

  assign ra_oh = NUM_REGS'(1) << ra;
  assign rb_oh = NUM_REGS'(1) << rb;
  assign rc_oh = NUM_REGS'(1) << rc;

  assign is_alu = (opcode >= OP_W'(OP_ALU_FIRST)) && (opcode <= OP_W'(OP_ALU_LAST));
`ifdef ALU_MULDIV_EN
  assign is_muldiv = (opcode == OP_W'(OP_MUL)) || (opcode == OP_W'(OP_DIV));
`else
  assign is_muldiv = 1'b0;
`endif
  assign legal = is_alu || is_muldiv;

endmodule

// File: rtl/alu_seq_ctrl.sv
// Microstep sequencer: T0-T2 fetch, T3 operand, T4 ALU, T5(/T6) writeback; strobes decoded from state.
// Done 6 cycles after start (7 with MUL/DIV under ALU_MULDIV_EN) plus T1 memory wait cycles.
module alu_seq_ctrl
  import alu_seq_pkg::*;
#(
  parameter int DATA_W      = 32,
  parameter int NUM_REGS    = 16,
  parameter int OP_W        = 5,
  parameter int MEM_TIMEOUT = 15
) (
  input logic            clk,
  input logic            clr,
  alu_seq_ctrl_if.master io
);
  localparam int CNT_W = (MEM_TIMEOUT > 1) ? $clog2(MEM_TIMEOUT) : 1;
  localparam logic [CNT_W-1:0] LAST_WAIT = CNT_W'((MEM_TIMEOUT > 0) ? MEM_TIMEOUT - 1 : 0);

  state_t              state;
  logic [CNT_W-1:0]    wait_cnt;
  logic                bus_err_q;
  logic [OP_W-1:0]     opcode;
  logic [NUM_REGS-1:0] ra_oh, rb_oh, rc_oh;
  logic                legal, is_muldiv;

  alu_seq_decode #(
    .DATA_W   (DATA_W),
    .NUM_REGS (NUM_REGS),
    .OP_W     (OP_W)
  ) u_decode (
    .ir        (io.ir_in),
    .opcode    (opcode),
    .ra_oh     (ra_oh),
    .rb_oh     (rb_oh),
    .rc_oh     (rc_oh),
    .legal     (legal),
    .is_muldiv (is_muldiv)
  );

  // wait_cnt saturates so PC_rd cannot re-fire on wrap when MEM_TIMEOUT is 0.
  always_ff @(posedge clk) begin
    if (clr) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      bus_err_q <= 1'b0;
    end else begin
      bus_err_q <= 1'b0;
      wait_cnt  <= '0;
      case (state)
        ST_IDLE: if (io.start) state <= ST_T0;
        ST_T0:   state <= ST_T1;
        ST_T1: begin
          if (io.mem_ready) begin
            state <= ST_T2;
          end else if ((MEM_TIMEOUT != 0) && (wait_cnt == LAST_WAIT)) begin
            state     <= ST_IDLE;
            bus_err_q <= 1'b1;
          end else begin
            wait_cnt <= (wait_cnt == '1) ? wait_cnt : wait_cnt + 1'b1;
          end
        end
        ST_T2:   state <= ST_T3;
        ST_T3:   state <= legal ? ST_T4 : ST_IDLE;
        ST_T4:   state <= ST_T5;
        ST_T5: begin
          if (is_muldiv) state <= ST_T6;
          else           state <= io.start ? ST_T0 : ST_IDLE;
        end
        ST_T6:   state <= io.start ? ST_T0 : ST_IDLE;
        default: state <= ST_IDLE;
      endcase
    end
  end

  always_comb begin
    io.R_rd    = '0;
    io.R_wrt   = '0;
    io.op_sel  = '0;
    io.PC_out  = 1'b0;
    io.MDR_out = 1'b0;
    io.Zlo_out = 1'b0;
    io.Zhi_out = 1'b0;
    io.PC_rd   = 1'b0;
    io.MAR_rd  = 1'b0;
    io.MDR_rd  = 1'b0;
    io.IR_rd   = 1'b0;
    io.Y_rd    = 1'b0;
    io.Zlo_rd  = 1'b0;
    io.Zhi_rd  = 1'b0;
    io.HI_rd   = 1'b0;
    io.LO_rd   = 1'b0;
    io.IncPC   = 1'b0;
    io.Read    = 1'b0;
    io.done    = 1'b0;
    io.illegal = 1'b0;
    case (state)
      ST_T0: begin
        io.PC_out = 1'b1;
        io.MAR_rd = 1'b1;
        io.IncPC  = 1'b1;
        io.Zlo_rd = 1'b1;
      end
      ST_T1: begin
        io.Zlo_out = 1'b1;
        io.PC_rd   = (wait_cnt == '0);
        io.Read    = 1'b1;
        io.MDR_rd  = io.mem_ready;
      end
      ST_T2: begin
        io.MDR_out = 1'b1;
        io.IR_rd   = 1'b1;
      end
      // Illegal opcodes drive nothing onto the bus before the trap.
      ST_T3: begin
        if (legal) begin
          io.R_wrt = rb_oh;
          io.Y_rd  = 1'b1;
        end else begin
          io.illegal = 1'b1;
        end
      end
      ST_T4: begin
        io.R_wrt  = rc_oh;
        io.op_sel = opcode;
        io.Zlo_rd = 1'b1;
        io.Zhi_rd = is_muldiv;
      end
      ST_T5: begin
        io.Zlo_out = 1'b1;
        if (is_muldiv) begin
          io.LO_rd = 1'b1;
        end else begin
          io.R_rd = ra_oh;
          io.done = 1'b1;
        end
      end
`ifdef ALU_MULDIV_EN
      ST_T6: begin
        io.Zhi_out = 1'b1;
        io.HI_rd   = 1'b1;
        io.done    = 1'b1;
      end
`endif
      default: ;
    endcase
  end

  assign io.busy       = (state != ST_IDLE);
  assign io.bus_err    = bus_err_q;
  assign io.state_view = state;

endmodule

// File: tb/tb_alu_seq_ctrl.sv
// Directed scoreboard bench for alu_seq_ctrl (MEM_TIMEOUT=4): per-cycle state/strobe checks
// against a table model, plus completion events matched against a queue of expected results.
module tb_alu_seq_ctrl;
  import alu_seq_pkg::*;

  localparam int TO    = 4;
  localparam int C_ALU = 0;
  localparam int C_MD  = 1;
  localparam int C_ILL = 2;
  localparam int C_TO  = 3;

  typedef struct {
    int kind;
    int cyc;
  } exp_t;

  logic clk = 1'b0;
  logic clr;
  int   checks = 0;
  int   errors = 0;
  int   md_cls;
  exp_t exp_q[$];

  alu_seq_ctrl_if #(.DATA_W(32), .NUM_REGS(16), .OP_W(5)) bus ();

  alu_seq_ctrl #(
    .DATA_W      (32),
    .NUM_REGS    (16),
    .OP_W        (5),
    .MEM_TIMEOUT (TO)
  ) dut (
    .clk (clk),
    .clr (clr),
    .io  (bus)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed 0x%0h, expected 0x%0h", tag, obs, exp);
    end
  endtask

  function automatic logic [55:0] obs_vec();
    return {bus.R_rd, bus.R_wrt, bus.op_sel, bus.PC_out, bus.MDR_out, bus.Zlo_out, bus.Zhi_out,
            bus.PC_rd, bus.MAR_rd, bus.MDR_rd, bus.IR_rd, bus.Y_rd, bus.Zlo_rd, bus.Zhi_rd,
            bus.HI_rd, bus.LO_rd, bus.IncPC, bus.Read, bus.busy, bus.done, bus.illegal, bus.bus_err};
  endfunction

  // Expected state in cycle c after start was sampled; w = T1 wait cycles before mem_ready.
  function automatic state_t exp_state(input int c, input int w, input int cls, input bit hold);
    if (c == 1) return ST_T0;
    if (cls == C_TO) return (c <= 1 + TO) ? ST_T1 : ST_IDLE;
    if (c <= 2 + w) return ST_T1;
    if (c == 3 + w) return ST_T2;
    if (c == 4 + w) return ST_T3;
    if (cls == C_ILL) return ST_IDLE;
    if (c == 5 + w) return ST_T4;
    if (c == 6 + w) return ST_T5;
    if ((c == 7 + w) && (cls == C_MD)) return ST_T6;
    return hold ? ST_T0 : ST_IDLE;
  endfunction

  function automatic logic [55:0] exp_vec(input state_t st, input int c, input int w, input int cls,
                                          input logic [4:0] opc, input logic [3:0] ra,
                                          input logic [3:0] rb, input logic [3:0] rc);
    logic [15:0] rrd, rwrt;
    logic [4:0]  ops;
    logic pc_out, mdr_out, zlo_out, zhi_out, pc_rd, mar_rd, mdr_rd, ir_rd, y_rd;
    logic zlo_rd, zhi_rd, hi_rd, lo_rd, incpc, rd, dn, ill, berr;
    {rrd, rwrt, ops} = '0;
    {pc_out, mdr_out, zlo_out, zhi_out, pc_rd, mar_rd, mdr_rd, ir_rd, y_rd} = '0;
    {zlo_rd, zhi_rd, hi_rd, lo_rd, incpc, rd, dn, ill} = '0;
    case (st)
      ST_T0: {pc_out, mar_rd, incpc, zlo_rd} = 4'hF;
      ST_T1: begin
        zlo_out = 1'b1;
        rd      = 1'b1;
        pc_rd   = (c == 2);
        mdr_rd  = (cls != C_TO) && (c == 2 + w);
      end
      ST_T2: {mdr_out, ir_rd} = 2'b11;
      ST_T3: begin
        if (cls == C_ILL) ill = 1'b1;
        else begin
          rwrt = 16'h1 << rb;
          y_rd = 1'b1;
        end
      end
      ST_T4: begin
        rwrt   = 16'h1 << rc;
        ops    = opc;
        zlo_rd = 1'b1;
        zhi_rd = (cls == C_MD);
      end
      ST_T5: begin
        zlo_out = 1'b1;
        if (cls == C_MD) lo_rd = 1'b1;
        else begin
          rrd = 16'h1 << ra;
          dn  = 1'b1;
        end
      end
      ST_T6: {zhi_out, hi_rd, dn} = 3'b111;
      default: ;
    endcase
    berr = (cls == C_TO) && (c == 2 + TO);
    return {rrd, rwrt, ops, pc_out, mdr_out, zlo_out, zhi_out, pc_rd, mar_rd, mdr_rd, ir_rd, y_rd,
            zlo_rd, zhi_rd, hi_rd, lo_rd, incpc, rd, st != ST_IDLE, dn, ill, berr};
  endfunction

  // One instruction: clr_cyc != 0 asserts clr at the end of that cycle instead of completing.
  task automatic run(input string name, input logic [4:0] opc, input logic [3:0] ra,
                     input logic [3:0] rb, input logic [3:0] rc, input int w, input int cls,
                     input bit hold, input int clr_cyc);
    int     term, last, kind;
    bit     seen;
    exp_t   e;
    state_t st;
    term = (cls == C_TO) ? 2 + TO : (cls == C_ILL) ? 4 + w : (cls == C_MD) ? 7 + w : 6 + w;
    last = (clr_cyc != 0) ? clr_cyc : term;
    if (clr_cyc == 0) begin
      e.kind = (cls == C_TO) ? 2 : (cls == C_ILL) ? 1 : 0;
      e.cyc  = term;
      exp_q.push_back(e);
    end
    seen = 1'b0;
    bus.ir_in = {opc, ra, rb, rc, 15'h0};
    bus.start = 1'b1;
    for (int c = 1; c <= last; c++) begin
      @(posedge clk);
      #1;
      bus.start     = hold;
      bus.mem_ready = (cls != C_TO) && (c >= 2 + w);
      #1;
      st = exp_state(c, w, cls, hold);
      check($sformatf("%s state c%0d", name, c), 64'(bus.state_view), 64'(st));
      check($sformatf("%s outs c%0d", name, c), 64'(obs_vec()),
            64'(exp_vec(st, c, w, cls, opc, ra, rb, rc)));
      if ((bus.done || bus.illegal || bus.bus_err) && !seen) begin
        seen = 1'b1;
        checks++;
        assert (exp_q.size() > 0) else begin
          errors++;
          $error("FAIL %s event: observed completion at c%0d, expected none", name, c);
        end
        if (exp_q.size() > 0) begin
          e    = exp_q.pop_front();
          kind = bus.bus_err ? 2 : bus.illegal ? 1 : 0;
          check($sformatf("%s event kind", name), 64'(kind), 64'(e.kind));
          check($sformatf("%s event cycle", name), 64'(c), 64'(e.cyc));
        end
      end
    end
    if (clr_cyc != 0) begin
      clr       = 1'b1;
      bus.start = 1'b0;
      @(posedge clk);
      #2;
      check($sformatf("%s clr state", name), 64'(bus.state_view), 64'(ST_IDLE));
      check($sformatf("%s clr outs", name), 64'(obs_vec()), 64'h0);
      clr = 1'b0;
    end else begin
      checks++;
      assert (seen) else begin
        errors++;
        $error("FAIL %s event: observed none within %0d cycles, expected one", name, term);
        if (exp_q.size() > 0) exp_q.delete(0);
      end
      if (!hold) begin
        @(posedge clk);
        #2;
        check($sformatf("%s idle state", name), 64'(bus.state_view), 64'(ST_IDLE));
        check($sformatf("%s idle outs", name), 64'(obs_vec()), 64'h0);
      end
    end
  endtask

  initial begin
`ifdef ALU_MULDIV_EN
    md_cls = C_MD;
`else
    md_cls = C_ILL;
`endif
    clr           = 1'b1;
    bus.start     = 1'b0;
    bus.ir_in     = '0;
    bus.mem_ready = 1'b0;
    repeat (2) @(posedge clk);
    #2;
    check("reset state", 64'(bus.state_view), 64'(ST_IDLE));
    check("reset outs", 64'(obs_vec()), 64'h0);
    clr = 1'b0;

    run("shl",     5'h0B, 4'd4,  4'd3, 4'd7,  0, C_ALU, 1'b0, 0);
    run("wait3",   5'h03, 4'd1,  4'd2, 4'd3,  3, C_ALU, 1'b0, 0);
    run("timeout", 5'h05, 4'd1,  4'd1, 4'd1,  0, C_TO,  1'b0, 0);
    run("ill_1f",  5'h1F, 4'd9,  4'd8, 4'd10, 0, C_ILL, 1'b0, 0);
    run("alu_0e",  5'h0E, 4'd15, 4'd0, 4'd14, 1, C_ALU, 1'b0, 0);
    run("ill_02",  5'h02, 4'd3,  4'd3, 4'd3,  0, C_ILL, 1'b0, 0);
    run("mul",     5'h0F, 4'd2,  4'd5, 4'd6,  0, md_cls, 1'b0, 0);
    run("div",     5'h10, 4'd1,  4'd0, 4'd15, 2, md_cls, 1'b0, 0);
    run("t1_clr",  5'h04, 4'd0,  4'd0, 4'd0,  0, C_TO,  1'b0, 3);
    run("post",    5'h04, 4'd5,  4'd6, 4'd7,  2, C_ALU, 1'b0, 0);
    run("b2b_1",   5'h03, 4'd1,  4'd2, 4'd3,  0, C_ALU, 1'b1, 0);
    run("b2b_2",   5'h03, 4'd4,  4'd5, 4'd6,  0, C_ALU, 1'b1, 5);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
